aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//  Iterative AES encryption controller. Accepts one 128-bit plaintext block per handshake and steps it through
//  NR rounds on one shared round datapath (sub_bytes -> shift_rows -> aes_mix_column -> add_round_key), one round per cycle.
//  Skips mix_column in the final round. Fetches round keys by index from an external key store.
//  Sits between the bus/FIFO front end and the precomputed key-expansion RAM.
// PARAMETERS
//  NR      10   number of rounds; legal values 10/12/14 (AES-128/192/256); other values are an elaboration $fatal
// PORTS
//  clk_i        in   1          single clock; all logic on posedge
//  rst_i        in   1          synchronous, active-high reset
//  in_valid_i   in   1          plaintext block valid
//  in_ready_o   out  1          sequencer can accept a block
//  data_i       in   [0:15][7:0] plaintext; byte 0 = column 0 row 0 (column-major, same as mix_column state_i)
//  rk_idx_o     out  4          round-key index requested this cycle (0..NR)
//  rk_i         in   [0:15][7:0] round key for rk_idx_o, combinational same-cycle return
//  out_valid_o  out  1          ciphertext valid
//  out_ready_i  in   1          consumer accepts ciphertext
//  data_o       out  [0:15][7:0] ciphertext (the state register)
//  busy_o       out  1          high in ROUND or DONE
//  abort_i      in   1          only with AES_SEQ_ABORT_EN
// BEHAVIOUR
//  Reset (rst_i=1 at a posedge): FSM=IDLE, round_q=0, state_q=0. Outputs after reset: in_ready_o=1, out_valid_o=0,
//   busy_o=0, rk_idx_o=0, data_o=0. Reset mid-operation discards the block; no output is produced for it.
//  FSM IDLE:
//   in_ready_o=1, rk_idx_o=0.
//   On in_valid_i at a posedge: state_q <= data_i ^ rk_i (round 0), round_q <= 1, go to ROUND.
//  FSM ROUND:
//   in_ready_o=0, rk_idx_o=round_q.
//   Each posedge: state_q <= round(state_q, rk_i); round_q++.
//   round() omits mix_column when round_q==NR.
//   When round_q==NR, go to DONE.
//  FSM DONE:
//   out_valid_o=1, data_o stable; in_ready_o=0, rk_idx_o=0.
//   On out_ready_i at a posedge: go to IDLE.
//   Blocks presented with in_valid_i while ROUND or DONE are not accepted. The source must hold them (valid/ready rule).
//   in_ready_o is never asserted in the same cycle as out_valid_o.
//  Latency: accept at edge T; out_valid_o high from edge T+NR. Minimum throughput 1 block per NR+2 cycles.
//  Widths: round_q is 4 bits. rk_idx_o never exceeds NR and never wraps.
//  All outputs are registered or decoded from FSM/round_q only; none depends combinationally on rk_i or the handshake inputs.
// CONFIGURATION
//  AES_SEQ_ABORT_EN defined:
//   abort_i port exists.
//   abort_i=1 at a posedge in ROUND or DONE: FSM=IDLE, round_q=0, state_q=0; out_valid_o is not raised for that block.
//   abort_i ignored in IDLE. abort_i and in_valid_i in the same IDLE cycle: the block is accepted.
//   rst_i has priority over abort_i.
//  AES_SEQ_ABORT_EN undefined: no abort_i port; only rst_i ends an operation early.
// STRUCTURE
//  aes_pkg holds:
//   typedef logic [0:15][7:0] aes_state_t;
//   typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_seq_fsm_t;
//   localparam NR_AES128 = 10.
//  One sub-module, aes_round: combinational, ports state_i, rk_i, last_i, state_o.
//   Instantiates existing aes_sub_bytes, aes_shift_rows, aes_mix_column. last_i=1 bypasses mix_column.
//  The sequencer holds the FSM, round counter and state register only.
// TESTING
//  Bench supplies rk_i from a DPI-C key-expansion model, indexed by rk_idx_o. Ciphertext is checked against a DPI-C AES reference.
//  1 FIPS-197 C.1 vector:
//    key 000102..0f, pt 00112233445566778899aabbccddeeff, out_ready_i=1
//    -> data_o=69c4e0d86a7b0430d8cdb78070b4c55a with out_valid_o exactly 10 cycles after accept.
//  2 Random: 1000 random pt/key, random out_ready_i stalls -> every data_o matches the DPI model;
//    rk_idx_o sequence 0,1..10 per block.
//  3 Backpressure: out_ready_i=0 for 5 cycles in DONE
//    -> out_valid_o and data_o stay constant, in_ready_o=0 throughout; IDLE one cycle after out_ready_i=1.
//  4 Busy rejection: in_valid_i held high with a second block during ROUND
//    -> second block accepted only in the IDLE cycle after the first handshake; both results correct.
//  5 Reset mid-op: rst_i=1 when round_q==5
//    -> next cycle in_ready_o=1, out_valid_o=0, busy_o=0, data_o=0; next block encrypts correctly.
//  6 (AES_SEQ_ABORT_EN) abort_i pulse in round 3 -> IDLE next cycle, no out_valid_o.
//    abort_i in IDLE concurrent with in_valid_i -> block accepted.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the round datapath and the round sequencer.
package aes_pkg;

    typedef logic [0:15][7:0] aes_state_t;
    typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_seq_fsm_t;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned RK_IDX_W  = 4;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as b^254 (0 maps to 0), followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_mix_column.sv
// MixColumns over all four columns of the column-major state.
module aes_mix_column
    import aes_pkg::*;
(
    input  aes_state_t state_i,
    output aes_state_t state_o
);

    always_comb begin
        state_o = '0;
        for (int c = 0; c < 4; c++) begin
            state_o[4*c + 0] = xtime(state_i[4*c + 0]) ^ xtime(state_i[4*c + 1]) ^ state_i[4*c + 1]
                             ^ state_i[4*c + 2] ^ state_i[4*c + 3];
            state_o[4*c + 1] = state_i[4*c + 0] ^ xtime(state_i[4*c + 1]) ^ xtime(state_i[4*c + 2])
                             ^ state_i[4*c + 2] ^ state_i[4*c + 3];
            state_o[4*c + 2] = state_i[4*c + 0] ^ state_i[4*c + 1] ^ xtime(state_i[4*c + 2])
                             ^ xtime(state_i[4*c + 3]) ^ state_i[4*c + 3];
            state_o[4*c + 3] = xtime(state_i[4*c + 0]) ^ state_i[4*c + 0] ^ state_i[4*c + 1]
                             ^ state_i[4*c + 2] ^ xtime(state_i[4*c + 3]);
        end
    end

endmodule

// File: rtl/aes_round.sv
// One combinational AES encryption round; last_i drops MixColumns for the final round.
module aes_round
    import aes_pkg::*;
(
    input  aes_state_t state_i,
    input  aes_state_t rk_i,
    input  logic       last_i,
    output aes_state_t state_o
);

    aes_state_t sub_c;
    aes_state_t shift_c;
    aes_state_t mix_c;

    aes_sub_bytes u_sub_bytes (
        .state_i (state_i),
        .state_o (sub_c)
    );

    aes_shift_rows u_shift_rows (
        .state_i (sub_c),
        .state_o (shift_c)
    );

    aes_mix_column u_mix_column (
        .state_i (shift_c),
        .state_o (mix_c)
    );

    assign state_o = (last_i ? shift_c : mix_c) ^ rk_i;

endmodule

// File: rtl/aes_shift_rows.sv
// Cyclic left shift of row r by r columns; state is column-major (byte 4*c + r).
module aes_shift_rows
    import aes_pkg::*;
(
    input  aes_state_t state_i,
    output aes_state_t state_o
);

    always_comb begin
        state_o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                state_o[4*c + r] = state_i[4*((c + r) % 4) + r];
            end
        end
    end

endmodule

// File: rtl/aes_sub_bytes.sv
// Byte-wise S-box substitution over the full 16-byte state.
module aes_sub_bytes
    import aes_pkg::*;
(
    input  aes_state_t state_i,
    output aes_state_t state_o
);

    always_comb begin
        state_o = '0;
        for (int i = 0; i < 16; i++) begin
            state_o[i] = sbox(state_i[i]);
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption sequencer: one round per cycle, round keys fetched by index.
// Optional abort_i port and early-termination path enabled by defining AES_SEQ_ABORT_EN.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_AES128
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  aes_state_t          data_i,
    output logic [RK_IDX_W-1:0] rk_idx_o,
    input  aes_state_t          rk_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output aes_state_t          data_o,
    output logic                busy_o
`ifdef AES_SEQ_ABORT_EN
   ,input  logic                abort_i
`endif
);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_check
        $fatal(1, "aes_round_sequencer: NR must be 10, 12 or 14");
    end

    aes_seq_fsm_t        fsm_q;
    aes_seq_fsm_t        fsm_d;
    logic [RK_IDX_W-1:0] round_q;
    aes_state_t          state_q;
    aes_state_t          round_out_c;
    logic                last_c;
    logic                abort_c;

`ifdef AES_SEQ_ABORT_EN
    assign abort_c = abort_i;
`else
    assign abort_c = 1'b0;
`endif

    assign last_c = (round_q == RK_IDX_W'(NR));

    aes_round u_round (
        .state_i (state_q),
        .rk_i    (rk_i),
        .last_i  (last_c),
        .state_o (round_out_c)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) fsm_q <= IDLE;
        else       fsm_q <= fsm_d;
    end

    // Next-state decode
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (in_valid_i) fsm_d = ROUND;
            ROUND:   if (abort_c) fsm_d = IDLE;
                     else if (last_c) fsm_d = DONE;
            DONE:    if (abort_c || out_ready_i) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Outputs decoded from FSM state and round counter only
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        rk_idx_o    = '0;
        case (fsm_q)
            IDLE:    in_ready_o = 1'b1;
            ROUND: begin
                busy_o   = 1'b1;
                rk_idx_o = round_q;
            end
            DONE: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Round counter clears on the last round so rk_idx never passes NR.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            round_q <= '0;
            state_q <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_q <= data_i ^ rk_i;
                        round_q <= RK_IDX_W'(1);
                    end
                end
                ROUND: begin
                    if (abort_c) begin
                        state_q <= '0;
                        round_q <= '0;
                    end else begin
                        state_q <= round_out_c;
                        round_q <= last_c ? '0 : round_q + RK_IDX_W'(1);
                    end
                end
                DONE: begin
                    if (abort_c) begin
                        state_q <= '0;
                        round_q <= '0;
                    end
                end
                default: begin
                    state_q <= '0;
                    round_q <= '0;
                end
            endcase
        end
    end

    assign data_o = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: reference AES-128 model, random blocks and directed corner cases.
`timescale 1ns/1ps
module tb_aes_round_sequencer;

    typedef logic [0:15][7:0] blk_t;

    localparam int unsigned NR      = 10;
    localparam int unsigned TIMEOUT = 200;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [3:0] rk_idx;
    blk_t       data_in;
    blk_t       data_out;
    blk_t       rk;
`ifdef AES_SEQ_ABORT_EN
    logic       abort;
`endif

    blk_t        rk_tbl [0:15];
    logic [7:0]  sbox_t [0:255];
    blk_t        exp_q[$];
    int unsigned acc_q[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        rdy_rand = 1'b0;
    logic        prev_valid = 1'b0;
    blk_t        prev_out = '0;

    assign rk = rk_tbl[rk_idx];

    aes_round_sequencer #(.NR(NR)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (data_in),
        .rk_idx_o    (rk_idx),
        .rk_i        (rk),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (data_out),
        .busy_o      (busy)
`ifdef AES_SEQ_ABORT_EN
       ,.abort_i     (abort)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] m2(input logic [7:0] b);
        return (b << 1) ^ ((b & 8'h80) != 0 ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box built by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ m2(p);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    // AES-128 key schedule into rk_tbl[0..10].
    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rcon, 24'h0};
                rcon = m2(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk_tbl[r] = '0;
        for (int r = 0; r <= 10; r++) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic blk_t model_enc(input blk_t pt);
        blk_t s;
        blk_t t;
        logic [7:0] a0, a1, a2, a3;
        s = pt ^ rk_tbl[0];
        for (int r = 1; r <= int'(NR); r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c + row] = sbox_t[s[4*((c + row) % 4) + row]];
            if (r != int'(NR)) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
                    t[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
                end
            end
            s = t ^ rk_tbl[r];
        end
        return s;
    endfunction

    function automatic blk_t rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: protocol checks every cycle, scoreboard pop on output handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (!busy) begin
                check("idle_in_ready", 128'(in_ready), 128'(1));
                check("idle_out_valid", 128'(out_valid), 128'(0));
                check("idle_rk_idx", 128'(rk_idx), 128'(0));
            end else if (!out_valid) begin
                check("round_in_ready", 128'(in_ready), 128'(0));
                if (acc_q.size() == 0) check("round_no_block", 128'(busy), 128'(0));
                else check("rk_idx_seq", 128'(rk_idx), 128'(cyc - acc_q[0] + 1));
            end else begin
                check("done_in_ready", 128'(in_ready), 128'(0));
                check("done_rk_idx", 128'(rk_idx), 128'(0));
                if (acc_q.size() == 0 || exp_q.size() == 0) begin
                    check("unexpected_out_valid", 128'(out_valid), 128'(0));
                end else begin
                    if (!prev_valid) check("latency", 128'(cyc), 128'(acc_q[0] + NR));
                    else check("data_stable", data_out, prev_out);
                    if (out_ready) begin
                        check("ciphertext", data_out, exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            prev_valid = out_valid && !out_ready;
            prev_out   = data_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < int'(TIMEOUT); t++) begin
            if (in_ready) return;
            tick();
        end
        check("idle_timeout", 128'(in_ready), 128'(1));
    endtask

    task automatic send(input blk_t pt, input blk_t exp, output int unsigned acc);
        data_in  = pt;
        in_valid = 1'b1;
        acc      = 0;
        for (int t = 0; t < int'(TIMEOUT); t++) begin
            if (in_ready) begin
                acc = cyc + 1;
                exp_q.push_back(exp);
                acc_q.push_back(acc);
                tick();
                in_valid = 1'b0;
                data_in  = rnd128();
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        check("accept_timeout", 128'(in_ready), 128'(1));
    endtask

    task automatic wait_rk(input int unsigned idx);
        for (int t = 0; t < int'(TIMEOUT); t++) begin
            if (rk_idx == 4'(idx)) return;
            tick();
        end
        check("rk_wait_timeout", 128'(rk_idx), 128'(idx));
    endtask

    initial begin
        int unsigned acc_a;
        int unsigned acc_b;
        blk_t        pt;
        blk_t        exp;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
`ifdef AES_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        build_sbox();
        load_key(128'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rk_idx", 128'(rk_idx), 128'(0));
        check("rst_data_o", data_out, 128'h0);
        tick();

        // FIPS-197 C.1 known answer
        load_key(128'h000102030405060708090a0b0c0d0e0f);
        send(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, acc_a);
        wait_idle();

        // Random blocks with random output stalls
        rdy_rand = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            wait_idle();
            load_key(rnd128());
            pt = rnd128();
            send(pt, model_enc(pt), acc_a);
        end
        wait_idle();
        rdy_rand = 1'b0;
        tick();

        // Backpressure in DONE
        out_ready = 1'b0;
        wait_idle();
        load_key(rnd128());
        pt  = rnd128();
        exp = model_enc(pt);
        send(pt, exp, acc_a);
        for (int t = 0; t < int'(TIMEOUT) && !out_valid; t++) tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_data_o", data_out, exp);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_ready", 128'(in_ready), 128'(1));
        check("bp_release_valid", 128'(out_valid), 128'(0));

        // Second block held during ROUND is accepted only after the first drains
        load_key(rnd128());
        pt = rnd128();
        send(pt, model_enc(pt), acc_a);
        pt = rnd128();
        send(pt, model_enc(pt), acc_b);
        check("busy_reject_accept", 128'(acc_b), 128'(acc_a + NR + 2));
        wait_idle();

        // Reset in the middle of a block
        load_key(rnd128());
        pt = rnd128();
        send(pt, model_enc(pt), acc_a);
        wait_rk(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_data_o", data_out, 128'h0);
        tick();
        pt = rnd128();
        send(pt, model_enc(pt), acc_a);
        wait_idle();

`ifdef AES_SEQ_ABORT_EN
        // Abort in round 3, then abort in IDLE together with a new block
        pt = rnd128();
        send(pt, model_enc(pt), acc_a);
        wait_rk(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        acc_q.delete();
        check("abort_in_ready", 128'(in_ready), 128'(1));
        check("abort_out_valid", 128'(out_valid), 128'(0));
        check("abort_data_o", data_out, 128'h0);
        repeat (NR + 2) tick();
        abort = 1'b1;
        pt = rnd128();
        send(pt, model_enc(pt), acc_a);
        abort = 1'b0;
        wait_idle();
`endif

        repeat (3) tick();
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
